pwm_capture: RTL

Measures an incoming PWM waveform: high time and period, in clock cycles, with a one-cycle valid strobe per completed period and a stuck-level report when edges stop. It is the receive-side counterpart of the team's 10-bit PWM generator. It sits on an input pin or loopback path, so the generator's output can be checked in-system and externally driven PWM (fan tach, servo feedback) can be read.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/sync_2ff.sv | 25 ++
 rtl/pwm_capture.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
// Both ends import this so the counter width and duty width agree.
package pwm_pkg;

    localparam int CNT_W_DEFAULT = 12;
    localparam int PWM_DUTY_W    = 10;

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } cap_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous pin inputs.
// Output is low while reset is asserted.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and rising-to-rising period in clock cycles,
// strobes valid per completed period, and reports a stuck level when rises stop.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int TIMEOUT = 4095
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             stuck,
    output logic             stuck_level,
    output logic             valid
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    logic             w_s;
    logic             w_rise;
    logic             w_at_timeout;
    logic             r_s_d;

    cap_state_t       r_state;
    cap_state_t       w_state_next;

    logic [CNT_W-1:0] r_period_cnt;
    logic [CNT_W-1:0] w_period_cnt_next;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] w_high_cnt_next;
    logic [CNT_W-1:0] r_high_time;
    logic [CNT_W-1:0] w_high_time_next;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] w_period_next;
    logic             r_stuck;
    logic             w_stuck_next;
    logic             r_stuck_level;
    logic             w_stuck_level_next;
    logic             r_valid;
    logic             w_valid_next;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (pwm_in),
        .o_q   (w_s)
    );

    assign w_rise       = w_s & ~r_s_d;
    assign w_at_timeout = (r_period_cnt == TIMEOUT_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEEK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A rise always wins over the timeout, so a period of exactly TIMEOUT is
    // reported normally and the counters never need to exceed TIMEOUT.
    always_comb begin
        w_state_next       = r_state;
        w_period_cnt_next  = r_period_cnt;
        w_high_cnt_next    = r_high_cnt;
        w_high_time_next   = r_high_time;
        w_period_next      = r_period;
        w_stuck_next       = r_stuck;
        w_stuck_level_next = r_stuck_level;
        w_valid_next       = 1'b0;

        case (r_state)
            SEEK, MEASURE: begin
                if (w_rise) begin
                    if (r_state == MEASURE) begin
                        w_high_time_next = r_high_cnt;
                        w_period_next    = r_period_cnt;
                        w_stuck_next     = 1'b0;
                        w_valid_next     = 1'b1;
                    end
                    w_period_cnt_next = ONE;
                    w_high_cnt_next   = ONE;
                    w_state_next      = MEASURE;
                end else if (w_at_timeout) begin
                    w_stuck_next       = 1'b1;
                    w_stuck_level_next = w_s;
                    w_valid_next       = 1'b1;
                    w_high_time_next   = '0;
                    w_period_next      = '0;
                    w_state_next       = STUCK;
                end else begin
                    w_period_cnt_next = r_period_cnt + ONE;
                    if ((r_state == MEASURE) && w_s) begin
                        w_high_cnt_next = r_high_cnt + ONE;
                    end
                end
            end
            STUCK: begin
                if (w_rise) begin
                    w_period_cnt_next = ONE;
                    w_high_cnt_next   = ONE;
                    w_state_next      = MEASURE;
                end
            end
            default: begin
                w_state_next = SEEK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_d         <= 1'b0;
            r_period_cnt  <= '0;
            r_high_cnt    <= '0;
            r_high_time   <= '0;
            r_period      <= '0;
            r_stuck       <= 1'b0;
            r_stuck_level <= 1'b0;
            r_valid       <= 1'b0;
        end else begin
            r_s_d         <= w_s;
            r_period_cnt  <= w_period_cnt_next;
            r_high_cnt    <= w_high_cnt_next;
            r_high_time   <= w_high_time_next;
            r_period      <= w_period_next;
            r_stuck       <= w_stuck_next;
            r_stuck_level <= w_stuck_level_next;
            r_valid       <= w_valid_next;
        end
    end

    assign high_time   = r_high_time;
    assign period      = r_period;
    assign stuck       = r_stuck;
    assign stuck_level = r_stuck_level;
    assign valid       = r_valid;

endmodule
